// File: rtl/pcm_output_stage.sv
// pcm_output_stage: rounding shift gain, PCM saturation and FWFT output FIFO with sticky flags
module pcm_output_stage #(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 24,
    parameter int SHIFT_WIDTH = 5,
    parameter int DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic [SHIFT_WIDTH-1:0]     shift,
    input  logic                       flag_clr,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [OUT_WIDTH-1:0]       m_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       saturated
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

    logic signed [IN_WIDTH:0] ext, rnd, r;
    logic [OUT_WIDTH-1:0] clip, s1_data;
    logic clipped, s1_valid, s1_sat, full, pop, wr;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OUT_WIDTH-1:0] mem [DEPTH];

    // one extra bit keeps the rounding add from wrapping at full-scale input
    always_comb begin
        ext     = {in_data[IN_WIDTH-1], in_data};
        rnd     = (shift != '0) ? (IN_WIDTH+1)'(1) << (shift - 1'b1) : '0;
        r       = (ext + rnd) >>> shift;
        clipped = (r > MAXV) || (r < MINV);
        clip    = (r > MAXV) ? MAXV[OUT_WIDTH-1:0] : (r < MINV) ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
    end

    assign m_valid = fifo_level != '0;
    assign full    = fifo_level == LW'(DEPTH);
    assign pop     = m_valid && m_ready;
    assign wr      = s1_valid && (!full || pop);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_sat     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            saturated  <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= clip;
                s1_sat  <= clipped;
            end
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(wr) - LW'(pop);
            overflow   <= (s1_valid && !wr) || (overflow && !flag_clr);
            saturated  <= (s1_valid && s1_sat) || (saturated && !flag_clr);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= s1_data;
endmodule

// File: tb/tb_pcm_output_stage.sv
// tb_pcm_output_stage: directed vectors with a queue scoreboard checked by an output monitor
module tb_pcm_output_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  shift;
    logic        flag_clr;
    logic        m_ready;
    logic        m_valid;
    logic [23:0] m_data;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        saturated;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    pcm_output_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .shift(shift),
        .flag_clr(flag_clr), .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
        .fifo_level(fifo_level), .overflow(overflow), .saturated(saturated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", {8'h0, m_data}, 32'hDEAD);
            else chk("m_data", {8'h0, m_data}, {8'h0, exp_q.pop_front()});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] s);
        in_valid = 1'b1;
        in_data  = d;
        shift    = s;
        idle(1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && k < 60) begin
            idle(1);
            k++;
        end
        chk("drain_timeout", k < 60, 1);
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0; flag_clr = 1'b0; m_ready = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_flags", {overflow, saturated}, 0);

        // rounding and latency
        m_ready = 1'b1;
        exp_q.push_back(24'd2);
        send(32'd384, 5'd8);
        chk("lat_k", m_valid, 0);
        idle(1);
        chk("lat_k1", m_valid, 1);
        idle(2);
        chk("sat_clear", saturated, 0);

        exp_q.push_back(24'hFFFFFF);
        send(32'hFFFFFE80, 5'd8);
        exp_q.push_back(24'hFFFFFB);
        send(32'hFFFFFFFB, 5'd0);
        idle(4);

        // saturation both ways, then clear
        exp_q.push_back(24'h7FFFFF);
        send(32'h01000000, 5'd0);
        idle(3);
        chk("sat_pos_flag", saturated, 1);
        exp_q.push_back(24'h800000);
        send(32'hFF000000, 5'd0);
        idle(3);
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        chk("sat_cleared", saturated, 0);

        // overflow: 10 pushes into 8 slots with no reads
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) exp_q.push_back(24'(i));
            send(32'(i), 5'd0);
            if (i == 9) begin
                chk("full_level", fifo_level, 8);
                chk("ovf_before", overflow, 0);
            end
        end
        chk("ovf_after", overflow, 1);
        idle(2);
        chk("full_level_hold", fifo_level, 8);
        drain();
        chk("empty_m_valid", m_valid, 0);
        chk("empty_m_data", m_data, 0);
        chk("empty_level", fifo_level, 0);

        // full with simultaneous write and pop
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        m_ready = 1'b0;
        for (int i = 21; i <= 28; i++) begin
            exp_q.push_back(24'(i));
            send(32'(i), 5'd0);
        end
        idle(2);
        chk("full2_level", fifo_level, 8);
        exp_q.push_back(24'd29);
        send(32'd29, 5'd0);
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        chk("wr_pop_level", fifo_level, 8);
        chk("wr_pop_ovf", overflow, 0);
        drain();
        chk("wr_pop_ovf_end", overflow, 0);

        // asynchronous reset mid-stream
        m_ready = 1'b0;
        send(32'h7FFFFFFF, 5'd0);
        for (int i = 32; i <= 35; i++) send(32'(i), 5'd0);
        idle(2);
        chk("pre_rst_level", fifo_level, 5);
        chk("pre_rst_sat", saturated, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_flags", {overflow, saturated}, 0);
        exp_q.delete();
        idle(1);
        rst_n = 1'b1;
        exp_q.push_back(24'd77);
        send(32'd77, 5'd0);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pcm_output_stage.md
Name: pcm_output_stage

Overview:
- Sits directly downstream of the decimation chain and consumes its 32-bit signed, valid-only output stream (one sample per 64 input samples).
- Applies a run-time programmable right-shift gain with round-half-up, then saturates to a PCM word width.
- Buffers samples in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the consumer (serial interface or bus bridge).
- Reports overflow and saturation as sticky flags.

Parameters:
- IN_WIDTH, 32, width of the incoming decimated sample.
- OUT_WIDTH, 24, width of the output PCM word.
- SHIFT_WIDTH, 5, width of the shift control; shift range is 0..2^SHIFT_WIDTH-1.
- DEPTH, 8, FIFO depth in words; must be a power of two and at least 2.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  one-cycle strobe qualifying in_data; there is no backpressure upstream.
- in_data  in  IN_WIDTH  signed decimated sample.
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled with each in_valid.
- flag_clr  in  1  clears the overflow and saturated flags.
- m_ready  in  1  consumer ready.
- m_valid  out  1  FIFO non-empty.
- m_data  out  OUT_WIDTH  signed head-of-FIFO word; forced to 0 when m_valid=0.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one sample was dropped.
- saturated  out  1  sticky: at least one sample was clipped.

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - All pointers, the pipeline register and its valid bit, the level and both flags clear to 0.
  - m_valid=0 and m_data=0.
  - FIFO contents are discarded.
- Stage 1, registered, on in_valid:
  - Compute in IN_WIDTH+1 bits: r = (in_data + (shift>0 ? 2^(shift-1) : 0)) >>> shift.
  - Saturate r to OUT_WIDTH signed: if r > 2^(OUT_WIDTH-1)-1, output 2^(OUT_WIDTH-1)-1; if r < -2^(OUT_WIDTH-1), output -2^(OUT_WIDTH-1).
  - When clipping occurs, assert a sat event together with the result.
  - Register the result and set the stage-1 valid bit for exactly one cycle.
- Stage 2, FIFO write:
  - The stage-1 result is written at the next edge.
  - Latency: in_valid sampled at edge k gives m_valid high after edge k+1 (2 cycles) when the FIFO was empty.
- Read:
  - A pop occurs on an edge where m_valid && m_ready.
  - m_data always shows the oldest entry, first-word-fall-through.
- Full with a write and a pop in the same cycle: both occur; the level is unchanged; nothing is dropped.
- Full with a write and no pop: the new sample is dropped, overflow sets at that edge, and FIFO contents are unchanged.
- Empty: m_ready is ignored and the level never goes negative. If a write arrives while the FIFO is empty, it becomes visible the following cycle; there is no same-cycle bypass.
- fifo_level:
  - +1 on write-only, -1 on pop-only, unchanged on both or neither.
  - It is registered and updates on the same edge as the pointers.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty are derived from fifo_level.
- Flags:
  - flag_clr clears both flags at the next edge.
  - If a new overflow or sat event occurs on the same edge as flag_clr, that flag stays set (the event wins).
- Shift changes between samples take effect on the next in_valid. Samples already in the FIFO are not re-scaled.
- Back-to-back in_valid on consecutive cycles must be handled at full rate, one sample per cycle.

Test Plan:
- shift=8, in_data=384 (0x00000180), m_ready=1 -> m_valid 2 cycles after the strobe, m_data=2, saturated=0.
- shift=8, in_data=-384 (0xFFFFFE80) -> m_data=-1 (0xFFFFFF); with shift=0 and in_data=-5 -> m_data=-5, exact passthrough.
- shift=0, in_data=0x01000000 -> m_data=0x7FFFFF, saturated=1; then in_data=0xFF000000 -> m_data=0x800000. Pulse flag_clr with no event -> saturated=0.
- m_ready=0, push 10 samples valued 1..10 (shift=0) -> fifo_level=8, overflow=1 after the 9th. Then raise m_ready -> reads 1..8 in order, then m_valid=0 and m_data=0.
- With the FIFO full (level 8), m_ready=1 and in_valid in the same cycle -> level stays 8, no overflow, and the read order is preserved with the new sample at the tail.
- Fill 5 entries, assert rst_n=0 mid-stream for 1 cycle -> m_valid=0, fifo_level=0, flags=0 immediately (asynchronous). The next pushed sample is the first one read.
